// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-side redirect/flush/stall/halt controller.
// Every output is registered from the next state, so each one reflects the state it belongs to.
module fetch_ctrl #(
    parameter int                  instSize    = 24,
    parameter int                  flushDepth  = 2,
    parameter logic [7:0]          haltOp      = 8'hFF,
    parameter logic [instSize-9:0] resetVector = '0
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic                stall_i,
    input  logic                branch_req_i,
    input  logic [instSize-9:0] branch_target_i,
    input  logic [instSize-1:0] instruction_i,
    output logic                pc_wr_en_o,
    output logic [instSize-9:0] new_pc_o,
    output logic                fetch_en_o,
    output logic                flush_o,
    output logic                halted_o,
    output logic [15:0]         stall_cnt_o
);
    typedef enum logic [2:0] {IDLE, REDIRECT, FLUSH, RUN, STALL, HALT} state_t;
    localparam logic [2:0] FD1 = 3'(flushDepth - 1);
    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [instSize-9:0] new_pc_q, new_pc_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;
    logic                pc_wr_en_q, pc_wr_en_d;
    logic                fetch_en_q, fetch_en_d;
    logic                flush_q, flush_d;
    logic                halted_q, halted_d;
    logic                unused_instr;
    assign unused_instr = ^instruction_i[instSize-9:0];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            new_pc_q    <= resetVector;
            stall_cnt_q <= '0;
            pc_wr_en_q  <= 1'b0;
            fetch_en_q  <= 1'b0;
            flush_q     <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
            pc_wr_en_q  <= pc_wr_en_d;
            fetch_en_q  <= fetch_en_d;
            flush_q     <= flush_d;
            halted_q    <= halted_d;
        end
    end
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        new_pc_d    = new_pc_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            IDLE, HALT: begin
                if (start_i) begin
                    state_d     = REDIRECT;
                    new_pc_d    = resetVector;
                    stall_cnt_d = '0;
                end
            end
            REDIRECT: begin
                state_d = (FD1 == 3'd0) ? RUN : FLUSH;
                cnt_d   = FD1;
            end
            FLUSH: begin
                // a new branch restarts the whole redirect; stall waits for RUN
                if (branch_req_i) begin
                    state_d  = REDIRECT;
                    new_pc_d = branch_target_i;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                    state_d = (cnt_q <= 3'd1) ? RUN : FLUSH;
                end
            end
            RUN: begin
                if (branch_req_i) begin
                    state_d  = REDIRECT;
                    new_pc_d = branch_target_i;
                end else if (stall_i) state_d = STALL;
                else if (instruction_i[instSize-1 -: 8] == haltOp) state_d = HALT;
            end
            STALL: begin
                if (branch_req_i) begin
                    state_d  = REDIRECT;
                    new_pc_d = branch_target_i;
                end else if (!stall_i) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == STALL && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    end
    always_comb begin
        pc_wr_en_d = state_d == REDIRECT;
        flush_d    = state_d inside {REDIRECT, FLUSH};
        fetch_en_d = state_d inside {REDIRECT, FLUSH, RUN};
        halted_d   = state_d == HALT;
    end
    assign pc_wr_en_o  = pc_wr_en_q;
    assign new_pc_o    = new_pc_q;
    assign fetch_en_o  = fetch_en_q;
    assign flush_o     = flush_q;
    assign halted_o    = halted_q;
    assign stall_cnt_o = stall_cnt_q;
endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 The block SHALL have parameter instSize, default 24, instruction width; PC width is instSize-8.
REQ-002 The block SHALL have parameter flushDepth, default 2, bubble cycles squashed after a redirect (range 1..7).
REQ-003 The block SHALL have parameter haltOp, default 8'hFF, opcode in instruction[instSize-1:instSize-8] that halts fetch.
REQ-004 The block SHALL have parameter resetVector, default 0, PC loaded on start.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  begin or restart fetch from resetVector.
REQ-008 stall  in  1  downstream hold request.
REQ-009 branchReq  in  1  resolved taken branch or jump.
REQ-010 branchTarget  in  instSize-8  branch destination PC.
REQ-011 instruction  in  instSize  word currently returned by fetch.
REQ-012 pcWrEn  out  1  one-cycle pulse telling fetch to load newPc.
REQ-013 newPc  out  instSize-8  registered redirect PC.
REQ-014 fetchEn  out  1  PC may advance this cycle.
REQ-015 flush  out  1  squash the IF/ID instruction.
REQ-016 halted  out  1  fetch stopped on haltOp.
REQ-017 stallCnt  out  16  count of cycles spent in STALL.

Function
REQ-018 The FSM SHALL have states IDLE, REDIRECT, FLUSH, RUN, STALL and HALT; all outputs SHALL be registered.
REQ-019 IDLE: fetchEn=0; start=1 -> REDIRECT with newPc<=resetVector.
REQ-020 REDIRECT SHALL last exactly 1 cycle with pcWrEn=1, fetchEn=1, flush=1, then go to FLUSH.
REQ-021 newPc SHALL stay stable from the REDIRECT cycle through the following cycle, covering fetch's one-cycle pcWrEn delay.
REQ-022 FLUSH SHALL assert flush=1 and fetchEn=1 for flushDepth-1 cycles, using a 3-bit down-counter, then go to RUN.
REQ-023 RUN: fetchEn=1 and flush=0.
REQ-024 RUN exits SHALL follow this priority: branchReq -> REDIRECT (newPc<=branchTarget), else stall -> STALL, else instruction opcode==haltOp -> HALT.
REQ-025 STALL: fetchEn=0; stallCnt SHALL increment each STALL cycle and saturate at 16'hFFFF.
REQ-026 STALL exits: branchReq -> REDIRECT; otherwise stall=0 -> RUN.
REQ-027 HALT: fetchEn=0, halted=1; start -> REDIRECT to resetVector, and halted SHALL clear on that transition; branchReq SHALL be ignored.
REQ-028 branchReq in FLUSH SHALL re-enter REDIRECT with the new target and restart the flush count; stall in FLUSH SHALL be deferred until RUN.
REQ-029 start in RUN, STALL or FLUSH SHALL be ignored.
REQ-030 stallCnt SHALL clear only on reset, or on start accepted from IDLE or HALT.
REQ-031 pcWrEn SHALL never be high on two consecutive cycles unless two consecutive redirects occur, and SHALL be 0 in all states other than REDIRECT.

Reset
REQ-032 reset=0 SHALL immediately force IDLE, pcWrEn=0, newPc=resetVector, fetchEn=0, flush=0, halted=0, stallCnt=0, and clear the flush counter.
REQ-033 Reset asserted mid-redirect or mid-flush SHALL abandon the operation; after release the block SHALL remain in IDLE until start.

Verification
REQ-034 Release reset, pulse start -> pcWrEn=1 for 1 cycle, newPc=0x0000, flush high for 2 cycles, then fetchEn=1 and flush=0.
REQ-035 In RUN, branchReq=1 with branchTarget=0x0040 -> next cycle pcWrEn=1, newPc=0x0040 held 2 cycles, flush high for 2 cycles.
REQ-036 In RUN, stall high for 5 cycles -> fetchEn=0 for 5 cycles, stallCnt=5, RUN resumes the cycle after stall falls.
REQ-037 In RUN, instruction=24'hFF0000 -> halted=1 and fetchEn=0; branchReq ignored; start -> newPc=resetVector and halted=0.
REQ-038 branchReq together with stall in RUN -> REDIRECT taken and stallCnt unchanged; branchReq again during FLUSH -> second pcWrEn with the new target and flush extended.
REQ-039 Assert reset during FLUSH -> all outputs at reset values asynchronously, before the next clock edge; no pcWrEn after release until start.
